// File: rtl/tlul_dev_to_mem.sv
// TL-UL device adapter: turns A-channel requests into a req/gnt/rvalid word memory
// access and returns in-order D-channel responses, answering malformed requests locally.
package tlul_dev_to_mem_pkg;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [15:0] a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [15:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  localparam logic [2:0] OpPutFullData    = 3'd0;
  localparam logic [2:0] OpPutPartialData = 3'd1;
  localparam logic [2:0] OpGet            = 3'd4;
  localparam logic [2:0] OpAccessAck      = 3'd0;
  localparam logic [2:0] OpAccessAckData  = 3'd1;

endpackage

module tlul_dev_to_mem
  import tlul_dev_to_mem_pkg::*;
#(
  parameter int unsigned MemAw       = 14,
  parameter int unsigned Outstanding = 2,
  parameter bit          ReadOnly    = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  tl_h2d_t          tl_i,
  output tl_d2h_t          tl_o,
  output logic             mem_req_o,
  input  logic             mem_gnt_i,
  output logic             mem_we_o,
  output logic [3:0]       mem_be_o,
  output logic [MemAw-1:0] mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic             mem_rvalid_i,
  input  logic [31:0]      mem_rdata_i,
  input  logic             mem_err_i,
  output logic             busy_o
);

  localparam int unsigned   CW      = $clog2(Outstanding + 1);
  localparam int unsigned   PW      = (Outstanding > 1) ? $clog2(Outstanding) : 1;
  localparam logic [CW-1:0] Full    = CW'(Outstanding);
  localparam logic [PW-1:0] LastPtr = PW'(Outstanding - 1);

  typedef struct packed {
    logic       is_get;
    logic [1:0] size;
    logic [7:0] source;
    logic       local_err;
  } meta_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // hold register
  logic             hold_valid_q, hold_valid_d;
  logic             hold_err_q, hold_err_d;
  logic             hold_we_q, hold_we_d;
  logic [3:0]       hold_be_q, hold_be_d;
  logic [MemAw-1:0] hold_addr_q, hold_addr_d;
  logic [31:0]      hold_wdata_q, hold_wdata_d;

  // meta FIFO (occupancy is cnt), data FIFO, granted-but-unanswered count
  meta_t         meta_q [Outstanding];
  meta_t         meta_d [Outstanding];
  logic [PW-1:0] mwr_q, mwr_d, mrd_q, mrd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  rsp_t          data_q [Outstanding];
  rsp_t          data_d [Outstanding];
  logic [PW-1:0] dwr_q, dwr_d, drd_q, drd_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic [CW-1:0] pend_q, pend_d;

  logic       a_ready, accept, gnt_fire, rv_fire, d_valid, pop, dpop;
  logic       a_is_get, a_is_put, a_err, aligned;
  logic [3:0] lanes;
  meta_t      head;
  rsp_t       dhead;

  logic unused_tl;
  assign unused_tl = ^{tl_i.a_param, tl_i.a_user, tl_i.a_address[31:MemAw+2]};

  // Lanes a well-formed request of this size/offset may touch.
  always_comb begin
    lanes   = 4'b0000;
    aligned = 1'b0;
    case (tl_i.a_size)
      2'd0: begin lanes = 4'b0001 << tl_i.a_address[1:0]; aligned = 1'b1; end
      2'd1: begin lanes = 4'b0011 << tl_i.a_address[1:0]; aligned = ~tl_i.a_address[0]; end
      2'd2: begin lanes = 4'b1111; aligned = (tl_i.a_address[1:0] == 2'b00); end
      default: ;
    endcase
    a_is_get = (tl_i.a_opcode == OpGet);
    a_is_put = (tl_i.a_opcode == OpPutFullData) || (tl_i.a_opcode == OpPutPartialData);
    a_err    = !(a_is_get || a_is_put) || !aligned
            || (tl_i.a_mask == 4'b0000) || ((tl_i.a_mask & ~lanes) != 4'b0000)
            || ((tl_i.a_opcode == OpPutFullData) && (tl_i.a_mask != lanes))
            || (ReadOnly && a_is_put);
  end

  assign a_ready   = (cnt_q < Full) && !hold_valid_q;
  assign accept    = tl_i.a_valid && a_ready;
  assign mem_req_o = hold_valid_q && !hold_err_q;
  assign gnt_fire  = mem_req_o && mem_gnt_i;
  // An rvalid with nothing granted has no home; dropping it keeps the data FIFO bounded.
  assign rv_fire   = mem_rvalid_i && (pend_q != '0);
  assign head      = meta_q[mrd_q];
  assign dhead     = data_q[drd_q];
  assign d_valid   = (cnt_q != '0) && (head.local_err || (dcnt_q != '0));
  assign pop       = d_valid && tl_i.d_ready;
  assign dpop      = pop && !head.local_err;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_err_d   = hold_err_q;
    hold_we_d    = hold_we_q;
    hold_be_d    = hold_be_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    meta_d       = meta_q;
    mwr_d        = mwr_q;
    mrd_d        = mrd_q;
    data_d       = data_q;
    dwr_d        = dwr_q;
    drd_d        = drd_q;

    if (accept) begin
      hold_valid_d  = 1'b1;
      hold_err_d    = a_err;
      hold_we_d     = !a_is_get;
      hold_be_d     = tl_i.a_mask;
      hold_addr_d   = tl_i.a_address[MemAw+1:2];
      hold_wdata_d  = tl_i.a_data;
      meta_d[mwr_q] = '{is_get: a_is_get, size: tl_i.a_size, source: tl_i.a_source,
                        local_err: a_err};
      mwr_d         = ptr_inc(mwr_q);
    end else if (gnt_fire || (hold_valid_q && hold_err_q)) begin
      hold_valid_d = 1'b0;
    end
    if (pop) mrd_d = ptr_inc(mrd_q);

    if (rv_fire) begin
      data_d[dwr_q] = '{rdata: mem_rdata_i, err: mem_err_i};
      dwr_d         = ptr_inc(dwr_q);
    end
    if (dpop) drd_d = ptr_inc(drd_q);

    cnt_d  = cnt_q + CW'(accept) - CW'(pop);
    dcnt_d = dcnt_q + CW'(rv_fire) - CW'(dpop);
    pend_d = pend_q + CW'(gnt_fire) - CW'(rv_fire);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_valid_q <= 1'b0;
      hold_err_q   <= 1'b0;
      hold_we_q    <= 1'b0;
      hold_be_q    <= '0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      meta_q       <= '{default: '0};
      mwr_q        <= '0;
      mrd_q        <= '0;
      cnt_q        <= '0;
      data_q       <= '{default: '0};
      dwr_q        <= '0;
      drd_q        <= '0;
      dcnt_q       <= '0;
      pend_q       <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_err_q   <= hold_err_d;
      hold_we_q    <= hold_we_d;
      hold_be_q    <= hold_be_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      meta_q       <= meta_d;
      mwr_q        <= mwr_d;
      mrd_q        <= mrd_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      dwr_q        <= dwr_d;
      drd_q        <= drd_d;
      dcnt_q       <= dcnt_d;
      pend_q       <= pend_d;
    end
  end

  assign mem_we_o    = hold_we_q;
  assign mem_be_o    = hold_be_q;
  assign mem_addr_o  = hold_addr_q;
  assign mem_wdata_o = hold_wdata_q;
  assign busy_o      = hold_valid_q || (cnt_q != '0);

  // D fields come straight from FIFO heads, so they cannot move while stalled.
  always_comb begin
    tl_o          = '0;
    tl_o.a_ready  = a_ready;
    tl_o.d_valid  = d_valid;
    tl_o.d_opcode = head.is_get ? OpAccessAckData : OpAccessAck;
    tl_o.d_size   = head.size;
    tl_o.d_source = head.source;
    tl_o.d_error  = head.local_err || dhead.err;
    if (head.is_get) tl_o.d_data = tl_o.d_error ? 32'hFFFF_FFFF : dhead.rdata;
  end

endmodule
